// File: rtl/topn_batch_ctrl.sv
// Batch sequencer for the systolic top-N sorter: clear, load (descending), flush/drain framed burst.
// Optional TOPN_BATCH_STATS_EN adds stat_len/stat_drain outputs updated on each done pulse.
module topn_batch_ctrl #(
    parameter int N         = 22,
    parameter int WIDTH     = 8,
    parameter int DRAIN_MAX = 2*N+4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             srt_rst,
    output logic             srt_flush,
    output logic [WIDTH-1:0] srt_data_i,
    output logic             srt_data_i_v,
    input  logic [WIDTH-1:0] srt_data_o,
    input  logic             srt_data_o_v,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             done,
    output logic             done_err,
    output logic [1:0]       dbg_state
`ifdef TOPN_BATCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_len,
    output logic [CNT_W-1:0] stat_drain
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] N_C       = CNT_W'(N);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DRAIN_MAX - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] len, len_inc, emit, expected, drain_cnt;
    logic             accept, final_beat, timeout;

    // Handshake: a record transfers on a cycle where in_valid & in_ready are both high;
    // in_ready is only offered in LOAD, and the source must hold the record until then.
    assign in_ready = (state == S_LOAD);
    assign accept   = in_valid & in_ready;
    assign len_inc  = (len == {CNT_W{1'b1}}) ? len : len + CNT_W'(1);

    assign final_beat = (state == S_DRAIN) & srt_data_o_v & ((emit + CNT_W'(1)) == expected);
    assign timeout    = (state == S_DRAIN) & ~final_beat & (drain_cnt == DRAIN_END);

    assign srt_rst      = rst | (state == S_CLEAR);
    assign srt_flush    = (state == S_DRAIN);
    assign srt_data_i_v = accept;
    assign srt_data_i   = accept ? in_data : '0;

    // Drain exits the cycle after the final beat, so late sorter beats land in IDLE and are masked.
    assign out_valid = (state == S_DRAIN) & srt_data_o_v;
    assign out_data  = out_valid ? srt_data_o : '0;
    assign out_last  = final_beat;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_LOAD;
            S_LOAD:  if (accept && in_last) state_nxt = S_DRAIN;
            S_DRAIN: if (final_beat || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len       <= '0;
            emit      <= '0;
            expected  <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= 1'b0;
            done_err <= 1'b0;
            case (state)
                S_CLEAR: begin
                    len       <= '0;
                    emit      <= '0;
                    drain_cnt <= '0;
                end
                S_LOAD: begin
                    if (accept) begin
                        len <= len_inc;
                        if (in_last) expected <= (len_inc < N_C) ? len_inc : N_C;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                    if (out_valid) emit <= emit + CNT_W'(1);
                    if (final_beat || timeout) begin
                        done     <= 1'b1;
                        done_err <= timeout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TOPN_BATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_len   <= '0;
            stat_drain <= '0;
        end else if (final_beat || timeout) begin
            stat_len   <= len;
            stat_drain <= drain_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_topn_batch_ctrl.sv
// Bench for topn_batch_ctrl: table of batch scenarios, scripted sorter model, output scoreboard.
module tb_topn_batch_ctrl;
    localparam int N         = 22;
    localparam int WIDTH     = 8;
    localparam int DRAIN_MAX = 48;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid, in_last, in_ready;
    logic             srt_rst, srt_flush, srt_data_i_v, srt_data_o_v;
    logic [WIDTH-1:0] srt_data_i, srt_data_o, out_data;
    logic             out_valid, out_last, done, done_err;
    logic [1:0]       dbg_state;
`ifdef TOPN_BATCH_STATS_EN
    logic [CNT_W-1:0] stat_len, stat_drain;
`endif

    topn_batch_ctrl #(.N(N), .WIDTH(WIDTH), .DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .srt_rst(srt_rst), .srt_flush(srt_flush),
        .srt_data_i(srt_data_i), .srt_data_i_v(srt_data_i_v),
        .srt_data_o(srt_data_o), .srt_data_o_v(srt_data_o_v),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .done(done), .done_err(done_err), .dbg_state(dbg_state)
`ifdef TOPN_BATCH_STATS_EN
        , .stat_len(stat_len), .stat_drain(stat_drain)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int model_beats;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    vec_t vecs[7];
    logic [WIDTH:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int out_beats = 0;
    int last_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: every out_valid beat must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            logic [WIDTH:0] e;
            out_beats++;
            if (out_last) last_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0d last %0d, none expected", out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e[WIDTH-1:0]});
                chk("out_last", {31'd0, out_last}, {31'd0, e[WIDTH]});
            end
        end
    end

    task automatic run_batch(input int len, input int model_beats, input bit exp_err, input int exp_cnt);
        int d[64];
        int s[64];
        int k, tmp, drain_cycles, beats0, last0, nbeats;
        bit got_done;
        for (int i = 0; i < len; i++) begin
            d[i] = $urandom_range(0, 255);
            s[i] = d[i];
        end
        for (int i = 0; i < len; i++)
            for (int j = 0; j < len - 1 - i; j++)
                if (s[j] < s[j+1]) begin
                    tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
                end
        for (int i = len; i < 64; i++) s[i] = $urandom_range(0, 255);
        beats0 = out_beats;
        last0  = last_cnt;

        in_valid = 1'b1; in_data = 8'(d[0]); in_last = (len == 1);
        #1;
        chk("idle_ready", {31'd0, in_ready}, 0);
        chk("idle_srt_rst", {31'd0, srt_rst}, 0);
        cyc();
        chk("clear_ready", {31'd0, in_ready}, 0);
        chk("clear_srt_rst", {31'd0, srt_rst}, 1);
        chk("clear_data_i_v", {31'd0, srt_data_i_v}, 0);
        cyc();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                #1;
                chk("bubble_data_i_v", {31'd0, srt_data_i_v}, 0);
                chk("bubble_data_i", {24'd0, srt_data_i}, 0);
                cyc();
            end
            in_valid = 1'b1; in_data = 8'(d[i]); in_last = (i == len - 1);
            #1;
            chk("load_ready", {31'd0, in_ready}, 1);
            chk("load_data_i_v", {31'd0, srt_data_i_v}, 1);
            chk("load_data_i", {24'd0, srt_data_i}, d[i]);
            cyc();
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;

        k = 0; drain_cycles = 0; got_done = 1'b0;
        while (!got_done && drain_cycles < DRAIN_MAX + 8) begin
            if (k < model_beats && !(drain_cycles < 10 && $urandom_range(0, 3) == 0)) begin
                srt_data_o_v = 1'b1;
                srt_data_o   = 8'(s[k]);
                if (k < exp_cnt) exp_q.push_back({(k == exp_cnt - 1), 8'(s[k])});
                k++;
            end else begin
                srt_data_o_v = 1'b0;
                srt_data_o   = 8'($urandom_range(0, 255));
            end
            #1;
            chk("drain_flush", {31'd0, srt_flush}, 1);
            chk("drain_ready", {31'd0, in_ready}, 0);
            cyc();
            drain_cycles++;
            if (done) got_done = 1'b1;
        end
        chk("done_seen", {31'd0, got_done}, 1);
        chk("done_err", {31'd0, done_err}, {31'd0, exp_err});
        if (exp_err) chk("timeout_cycles", drain_cycles, DRAIN_MAX);
        chk("post_state", {30'd0, dbg_state}, 0);
        chk("post_flush", {31'd0, srt_flush}, 0);
`ifdef TOPN_BATCH_STATS_EN
        chk("stat_len", {16'd0, stat_len}, len);
        chk("stat_drain", {16'd0, stat_drain}, drain_cycles);
`endif
        // A beat still arriving from the sorter after the burst ends must be masked.
        if (k < model_beats) begin
            srt_data_o_v = 1'b1;
            srt_data_o   = 8'(s[k]);
        end else begin
            srt_data_o_v = 1'b0;
        end
        cyc();
        srt_data_o_v = 1'b0;
        chk("done_pulse", {31'd0, done}, 0);
        chk("err_pulse", {31'd0, done_err}, 0);
        nbeats = (model_beats < exp_cnt) ? model_beats : exp_cnt;
        chk("sb_empty", exp_q.size(), 0);
        chk("beat_count", out_beats - beats0, nbeats);
        chk("last_count", last_cnt - last0, exp_err ? 0 : 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        srt_data_o = '0; srt_data_o_v = 1'b0;
        vecs[0] = '{len: 5,  model_beats: 5,  exp_err: 1'b0, exp_cnt: 5};
        vecs[1] = '{len: 30, model_beats: 23, exp_err: 1'b0, exp_cnt: 22};
        vecs[2] = '{len: 5,  model_beats: 3,  exp_err: 1'b1, exp_cnt: 5};
        vecs[3] = '{len: 1,  model_beats: 1,  exp_err: 1'b0, exp_cnt: 1};
        vecs[4] = '{len: 22, model_beats: 22, exp_err: 1'b0, exp_cnt: 22};
        vecs[5] = '{len: 7,  model_beats: 7,  exp_err: 1'b0, exp_cnt: 7};
        vecs[6] = '{len: 23, model_beats: 22, exp_err: 1'b0, exp_cnt: 22};

        cyc(); cyc();
        chk("rst_srt_rst", {31'd0, srt_rst}, 1);
        chk("rst_state", {30'd0, dbg_state}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_done_err", {31'd0, done_err}, 0);
        chk("rst_flush", {31'd0, srt_flush}, 0);
`ifdef TOPN_BATCH_STATS_EN
        chk("rst_stat_len", {16'd0, stat_len}, 0);
        chk("rst_stat_drain", {16'd0, stat_drain}, 0);
`endif
        rst = 1'b0;
        cyc();
        chk("idle_srt_rst_low", {31'd0, srt_rst}, 0);

        for (int v = 0; v < 7; v++) begin
            run_batch(vecs[v].len, vecs[v].model_beats, vecs[v].exp_err, vecs[v].exp_cnt);
            cyc();
        end

        // Abort mid-LOAD after 4 beats, then a clean batch.
        in_valid = 1'b1; in_last = 1'b0; in_data = 8'd11;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 20);
            #1;
            chk("abort_load_ready", {31'd0, in_ready}, 1);
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("abort_state", {30'd0, dbg_state}, 0);
        chk("abort_ready", {31'd0, in_ready}, 0);
        chk("abort_done", {31'd0, done}, 0);
        rst = 1'b0;
        cyc();
        chk("abort_done_after", {31'd0, done}, 0);
        chk("abort_srt_rst", {31'd0, srt_rst}, 0);
        run_batch(5, 5, 1'b0, 5);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
